// File: rtl/uart_rx_deserialiser.sv
// UART receiver: 2-flop synchronised rx line, mid-bit sampling, LSB-first deserialisation.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and the parity_err strobe.
module uart_rx_deserialiser #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd5,
`endif
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity holds when data bits plus parity bit contain an even number of ones.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  logic                 meta_r;
  logic                 rx_s_r;
  state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
  logic [IDX_W-1:0]     idx_r, idx_nx_s;
  logic [DATA_BITS-1:0] shift_r, shift_nx_s;
  logic [DATA_BITS-1:0] data_r, data_nx_s;
  logic                 valid_r, valid_nx_s;
  logic                 ferr_r, ferr_nx_s;
  logic                 busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_r, par_nx_s;
  logic                 perr_r, perr_nx_s;
`endif

  // Two-flop synchroniser; idle-high so reset leaves the line looking idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b1;
      rx_s_r <= 1'b1;
    end else begin
      meta_r <= rx_in;
      rx_s_r <= meta_r;
    end
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
      data_r  <= {DATA_BITS{1'b0}};
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r   <= 1'b0;
      perr_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
      shift_r <= shift_nx_s;
      data_r  <= data_nx_s;
      valid_r <= valid_nx_s;
      ferr_r  <= ferr_nx_s;
      busy_r  <= (state_nx_s != IDLE);
`ifdef UART_RX_PARITY_EN
      par_r   <= par_nx_s;
      perr_r  <= perr_nx_s;
`endif
    end
  end

  // Next-state and datapath decode; strobes default low so each lasts one cycle.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    shift_nx_s = shift_r;
    data_nx_s  = data_r;
    valid_nx_s = 1'b0;
    ferr_nx_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx_s   = par_r;
    perr_nx_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        cnt_nx_s = CNT_ZERO;
        if (!rx_s_r) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_r == CNT_HALF) begin
          cnt_nx_s = CNT_ZERO;
          idx_nx_s = IDX_ZERO;
          if (!rx_s_r) begin
            state_nx_s = DATA;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nx_s   = CNT_ZERO;
          shift_nx_s = {rx_s_r, shift_r[DATA_BITS-1:1]};
          if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nx_s = PARITY;
`else
            state_nx_s = STOP;
`endif
          end else begin
            idx_nx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nx_s   = CNT_ZERO;
          par_nx_s   = rx_s_r;
          state_nx_s = STOP;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nx_s = CNT_ZERO;
          if (rx_s_r) begin
            data_nx_s  = shift_r;
            valid_nx_s = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_nx_s  = parity_mismatch(shift_r, par_r);
`endif
            state_nx_s = IDLE;
          end else begin
            ferr_nx_s  = 1'b1;
            state_nx_s = WAIT_HIGH;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        // Hold through a break so it yields a single frame error.
        if (rx_s_r) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_HIGH;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  assign rx_data    = data_r;
  assign rx_valid   = valid_r;
  assign frame_err  = ferr_r;
  assign rx_busy    = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_r;
`endif

endmodule
